// File: rtl/rst_seq_pkg.sv
// Shared types and elaboration helpers for the staggered reset sequencer.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_t;

  // True when val is representable in an unsigned field of the given width.
  function automatic bit fits(longint unsigned val, int unsigned width);
    return (width >= 64) || ((val >> width) == 0);
  endfunction

endpackage

// File: rtl/rst_sync.sv
// Two-flop reset synchronizer: asserts asynchronously, deasserts on the second clock edge.
module rst_sync (
  input  logic clk,
  input  logic arst,
  output logic srst
);

  logic meta;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      meta <= 1'b1;
      srst <= 1'b1;
    end else begin
      meta <= 1'b0;
      srst <= meta;
    end
  end

endmodule

// File: rtl/rst_seq_gen.sv
// Staggered multi-channel reset release with re-sequence request and heartbeat watchdog.
// Define WDT_AUTO_RST_EN to make watchdog expiry pulse timeout_o and re-sequence automatically.
module rst_seq_gen
  import rst_seq_pkg::*;
#(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned INIT_DLY  = 16,
  parameter int unsigned STAGE_DLY = 100,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned TIMEOUT   = 1000000,
  parameter int unsigned TO_W      = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              hb_i,
  output logic [NUM_CH-1:0] rst_o,
  output logic [NUM_CH-1:0] rst_n_o,
  output logic              done_o,
  output logic              busy_o,
  output logic              timeout_o
);

  localparam logic [CNT_W-1:0]  INIT_LAST  = CNT_W'(INIT_DLY - 1);
  localparam logic [CNT_W-1:0]  STAGE_LAST = CNT_W'(STAGE_DLY - 1);
  localparam logic [TO_W-1:0]   TO_LAST    = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [NUM_CH-1:0] LAST_MASK  = NUM_CH'(1) << (NUM_CH - 1);
  localparam bit                WDT_ON     = (TIMEOUT > 0);

  if (NUM_CH == 0 || INIT_DLY == 0 || STAGE_DLY == 0 ||
      !fits(INIT_DLY, CNT_W) || !fits(STAGE_DLY, CNT_W) || !fits(TIMEOUT, TO_W)) begin : g_param_err
    $error("rst_seq_gen: invalid parameter set");
  end

  logic              rst_s;
  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [TO_W-1:0]   wcnt;
  logic [NUM_CH-1:0] rst_q;
  logic              done_q, busy_q, timeout_q;
  logic              step, reseq;

  rst_sync u_rst_sync (
    .clk  (clk_i),
    .arst (rst_i),
    .srst (rst_s)
  );

  always_comb begin
    step = 1'b0;
    case (state)
      HOLD:    step = (cnt == INIT_LAST);
      RELEASE: step = (cnt == STAGE_LAST);
      default: step = 1'b0;
    endcase
  end

  always_comb begin
    reseq = req_i;
`ifdef WDT_AUTO_RST_EN
    if (WDT_ON && state == RUN && !hb_i && wcnt == TO_LAST)
      reseq = 1'b1;
`endif
  end

  always_ff @(posedge clk_i or posedge rst_s) begin
    if (rst_s) begin
      state     <= HOLD;
      cnt       <= '0;
      wcnt      <= '0;
      rst_q     <= '1;
      done_q    <= 1'b0;
      busy_q    <= 1'b1;
      timeout_q <= 1'b0;
    end else begin
`ifdef WDT_AUTO_RST_EN
      timeout_q <= 1'b0;
`endif
      if (reseq) begin
        state     <= HOLD;
        cnt       <= '0;
        wcnt      <= '0;
        rst_q     <= '1;
        done_q    <= 1'b0;
        busy_q    <= 1'b1;
        // Only a watchdog-initiated re-sequence reports expiry; req_i always wins.
        timeout_q <= ~req_i;
      end else if (step) begin
        // Released bits form a contiguous low run, so this clears the lowest still-set bit.
        rst_q <= rst_q & (rst_q << 1);
        cnt   <= '0;
        if (rst_q == LAST_MASK) begin
          state  <= RUN;
          done_q <= 1'b1;
          busy_q <= 1'b0;
          wcnt   <= '0;
        end else begin
          state <= RELEASE;
        end
      end else begin
        case (state)
          HOLD, RELEASE: if (cnt != '1) cnt <= cnt + 1'b1;
          RUN: begin
            if (WDT_ON && !timeout_q) begin
              if (hb_i)                 wcnt      <= '0;
              else if (wcnt != TO_LAST) wcnt      <= wcnt + 1'b1;
              else                      timeout_q <= 1'b1;
            end
          end
          default: state <= HOLD;
        endcase
      end
    end
  end

  assign rst_o     = rst_q;
  assign rst_n_o   = ~rst_q;
  assign done_o    = done_q;
  assign busy_o    = busy_q;
  assign timeout_o = timeout_q;

endmodule

// File: doc/rst_seq_gen.md
Name: rst_seq_gen

Overview:
- Synthesizable, parametrised successor to the bench clock/reset generator.
- Releases NUM_CH reset domains in a staggered, cycle-exact sequence after a global reset.
- Provides both reset polarities per channel, a software re-sequence request, and a heartbeat watchdog (the synthesizable form of the bench timeout).
- Sits at the top of the DSP/FIFO datapath and drives per-block resets.

Parameters:
NUM_CH, 4, number of reset channels (>=1)
INIT_DLY, 16, cycles from synchronized reset release to channel 0 release (>=1)
STAGE_DLY, 100, cycles between successive channel releases (>=1)
CNT_W, 16, sequence counter width; must hold max(INIT_DLY, STAGE_DLY), else elaboration error
TIMEOUT, 1000000, watchdog cycles without heartbeat; 0 disables watchdog
TO_W, 32, watchdog counter width; must hold TIMEOUT

Ports:
clk_i  in  1  single clock
rst_i  in  1  asynchronous, active-high reset
req_i  in  1  re-sequence request, sampled on clk_i
hb_i  in  1  watchdog heartbeat (kick), sampled on clk_i
rst_o  out  NUM_CH  per-channel active-high reset
rst_n_o  out  NUM_CH  per-channel active-low reset, always equal to ~rst_o
done_o  out  1  all channels released
busy_o  out  1  sequence in progress (state != RUN)
timeout_o  out  1  watchdog expiry

Behaviour:
- Reset values: rst_o = all 1, rst_n_o = all 0, done_o = 0, busy_o = 1, timeout_o = 0.
- rst_i assertion:
  - All outputs take their reset values asynchronously, with no clock edge required.
  - rst_i deassertion passes through a 2-flop synchronizer.
  - T0 is the edge on which the synchronized reset first samples low.
- FSM states: HOLD, RELEASE, RUN.
- HOLD: counter counts from 0. Channel 0 deasserts at edge T0+INIT_DLY; FSM moves to RELEASE.
- RELEASE:
  - Channel k deasserts at edge T0+INIT_DLY+k*STAGE_DLY.
  - On the edge that releases channel NUM_CH-1, FSM moves to RUN; done_o=1 and busy_o=0 on that same edge.
  - With NUM_CH=1, the FSM goes HOLD->RUN directly.
- Released channels stay low until re-sequenced. Release order is strictly ascending by channel index.
- req_i=1 at an edge, in any state:
  - All rst_o reassert on that edge; done_o=0, busy_o=1, timeout_o clears.
  - FSM goes to HOLD with the counter cleared; that edge becomes the new T0.
  - req_i held high keeps the block in HOLD with the counter at 0.
- Watchdog (active in RUN only, TIMEOUT>0):
  - Counter clears on entry to RUN and on every edge with hb_i=1; otherwise it increments.
  - When the counter equals TIMEOUT-1 and hb_i=0, the expiry fires on the next edge. Net effect: TIMEOUT consecutive edges without a heartbeat trigger expiry.
- Priority: rst_i > req_i > hb_i > expiry.
  - req_i and expiry on the same edge: treated as req, timeout_o not set.
  - hb_i on the expiry edge: no expiry.
- Counters saturate and never wrap.

Optional Feature:
- Macro: WDT_AUTO_RST_EN.
- Defined: expiry makes timeout_o a 1-cycle pulse and performs a re-sequence identical to req_i on the same edge (rst_o all 1, FSM->HOLD).
- Undefined:
  - timeout_o is sticky at 1; the watchdog counter stops and channels remain released.
  - It clears only via req_i or rst_i.

Decomposition:
- Shared include rst_seq_pkg holds:
  - FSM state encodings (HOLD=2'd0, RELEASE=2'd1, RUN=2'd2).
  - Parameter-check macros.
- One sub-module: rst_sync.
  - 2-flop reset synchronizer: async assert, sync deassert, active-high in and out.
  - Reusable by the async FIFO domains.

Test Plan:
All scenarios use NUM_CH=4, INIT_DLY=4, STAGE_DLY=3, TIMEOUT=10; E2 denotes T0.
1. Release rst_i -> rst_o bits clear in order: ch0 at E6, ch1 at E9, ch2 at E12, ch3 at E15. done_o and busy_o=0 at E15; rst_n_o == ~rst_o throughout.
2. Assert rst_i at E10 minus 3 ns (between edges) -> rst_o=4'b1111, done_o=0 immediately; no edge required.
3. req_i pulse at edge E in RUN -> rst_o=4'b1111 at E, ch0 released at E+4, done_o at E+13. A second req_i at E+5 restarts the sequence, with ch0 reasserted at E+5.
4. hb_i every 5 edges -> timeout_o stays 0. Stop hb_i after edge H -> timeout_o=1 at H+10; sticky without the macro, channels still released.
5. hb_i=1 exactly at counter=9 -> no timeout. req_i at the expiry edge -> re-sequence with timeout_o=0.
6. WDT_AUTO_RST_EN defined, hb_i stopped -> timeout_o 1-cycle pulse at H+10, rst_o=4'b1111 on that edge, full sequence repeats (done_o at H+23).
